// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: tracks EX/MEM producers,
// registers the EX operand forwarding selects and drives stall/flush of the pipe registers.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_is_load,
   input  logic              ex_redirect,
   input  logic              mem_busy,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_em,
   output logic              flush_d,
   output logic              flush_e,
   output logic [CNT_W-1:0]  load_use_cnt
);

   // Selects are computed one cycle ahead, so the instruction leaving MEM is the
   // oldest producer ever consulted; no WB record or MEM load flag is needed.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              is_load;
   } ex_rec_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
   } mem_rec_t;

   ex_rec_t    ex_q;
   mem_rec_t   mem_q;
   logic       load_use;
   logic [1:0] sel_a_nxt;
   logic [1:0] sel_b_nxt;

   // Nearest older writer wins: EX becomes MEM (d2), MEM becomes WB (d1).
   function automatic logic [1:0] fwd_sel(input logic              valid,
                                          input logic [REG_AW-1:0] rs,
                                          input ex_rec_t           ex,
                                          input mem_rec_t          mem);
      logic [1:0] sel;
      sel = 2'b00;
      if (valid && rs != '0) begin
         if (ex.valid && ex.reg_write && ex.rd == rs)
            sel = 2'b10;
         else if (mem.valid && mem.reg_write && mem.rd == rs)
            sel = 2'b01;
      end
      return sel;
   endfunction

   assign load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.reg_write
                   & (ex_q.rd != '0) & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

   assign sel_a_nxt = fwd_sel(id_valid, id_rs1, ex_q, mem_q);
   assign sel_b_nxt = fwd_sel(id_valid, id_rs2, ex_q, mem_q);

   // NOTE: every output gets a default before the priority chain so no latch is inferred.
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_em = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      if (reset_n) begin
         if (mem_busy) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_em = 1'b1;
         end else if (ex_redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; mem_busy freezes everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_q         <= '0;
         mem_q        <= '0;
         fwd_a_sel    <= 2'b00;
         fwd_b_sel    <= 2'b00;
         load_use_cnt <= '0;
      end else if (!mem_busy) begin
         mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
         if (ex_redirect || load_use) begin
            ex_q      <= '0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
            if (!ex_redirect && load_use_cnt != '1)
               load_use_cnt <= load_use_cnt + CNT_W'(1);
         end else begin
            ex_q      <= '{valid:     id_valid,
                           rd:        id_rd,
                           reg_write: id_reg_write & id_valid,
                           is_load:   id_is_load & id_valid};
            fwd_a_sel <= sel_a_nxt;
            fwd_b_sel <= sel_b_nxt;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized traffic
// compared every cycle against an in-flight instruction queue model.
module tb_hazard_ctrl;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              id_valid, id_reg_write, id_is_load, ex_redirect, mem_busy;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic [1:0]        fwd_a_sel, fwd_b_sel;
   logic              stall_f, stall_d, stall_em, flush_d, flush_e;
   logic [CNT_W-1:0]  load_use_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy), .fwd_a_sel(fwd_a_sel),
      .fwd_b_sel(fwd_b_sel), .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
      .flush_d(flush_d), .flush_e(flush_e), .load_use_cnt(load_use_cnt)
   );

   // Reference model: queue of in-flight instructions, index 0 = youngest (EX).
   typedef struct {
      bit valid;
      int rd;
      bit rw;
      bit ld;
   } instr_t;

   instr_t pipe[$];
   int     m_sel_a, m_sel_b, m_cnt;
   int     vectors = 0;
   int     miscompares = 0;

   function automatic void m_reset();
      pipe.delete();
      m_sel_a = 0;
      m_sel_b = 0;
      m_cnt   = 0;
   endfunction

   // Distance to the nearest older in-flight writer of rs: 1 -> MEM result, 2 -> WB result.
   function automatic int fwd_of(int rs);
      if (!id_valid || rs == 0) return 0;
      for (int i = 0; i < pipe.size() && i < 2; i++)
         if (pipe[i].valid && pipe[i].rw && pipe[i].rd == rs)
            return (i == 0) ? 2 : 1;
      return 0;
   endfunction

   function automatic bit m_load_use();
      if (!id_valid || pipe.size() == 0) return 0;
      return pipe[0].valid && pipe[0].ld && pipe[0].rw && pipe[0].rd != 0 &&
             (pipe[0].rd == int'(id_rs1) || pipe[0].rd == int'(id_rs2));
   endfunction

   function automatic void m_next();
      instr_t nw;
      bit     lu;
      if (!reset_n || mem_busy) return;
      lu = m_load_use();
      if (ex_redirect || lu) begin
         nw = '{0, 0, 0, 0};
         m_sel_a = 0;
         m_sel_b = 0;
         if (!ex_redirect && m_cnt < CNT_MAX) m_cnt++;
      end else begin
         nw = '{id_valid, int'(id_rd), id_reg_write && id_valid, id_is_load && id_valid};
         m_sel_a = fwd_of(int'(id_rs1));
         m_sel_b = fwd_of(int'(id_rs2));
      end
      pipe.push_front(nw);
      if (pipe.size() > 2) void'(pipe.pop_back());
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      bit lu, sf, sd, se, fd, fe;
      lu = m_load_use();
      {sf, sd, se, fd, fe} = '0;
      if (reset_n) begin
         if (mem_busy)         {sf, sd, se} = 3'b111;
         else if (ex_redirect) {fd, fe} = 2'b11;
         else if (lu)          {sf, sd, fe} = 3'b111;
      end
      check("stall_f",      32'(stall_f),      32'(sf));
      check("stall_d",      32'(stall_d),      32'(sd));
      check("stall_em",     32'(stall_em),     32'(se));
      check("flush_d",      32'(flush_d),      32'(fd));
      check("flush_e",      32'(flush_e),      32'(fe));
      check("fwd_a_sel",    32'(fwd_a_sel),    32'(m_sel_a));
      check("fwd_b_sel",    32'(fwd_b_sel),    32'(m_sel_b));
      check("load_use_cnt", 32'(load_use_cnt), 32'(m_cnt));
   endtask

   task automatic drive(input logic rst, input logic v, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                        input logic rw, input logic ld, input logic redir, input logic busy);
      @(negedge clk);
      reset_n = rst; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_reg_write = rw; id_is_load = ld; ex_redirect = redir; mem_busy = busy;
      if (!rst) m_reset();
      #1 compare();
   endtask

   task automatic op(input logic v, input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                     input logic [REG_AW-1:0] rd, input logic rw, input logic ld);
      drive(1'b1, v, rs1, rs2, rd, rw, ld, 1'b0, 1'b0);
   endtask

   task automatic tick();
      m_next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      {id_valid, id_reg_write, id_is_load, ex_redirect, mem_busy} = '0;
      {id_rs1, id_rs2, id_rd} = '0;
      m_reset();

      // Reset with random inputs: everything reads zero.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         check("rst_stalls", {29'd0, stall_f, stall_d, stall_em}, 32'd0);
         check("rst_flush",  {30'd0, flush_d, flush_e}, 32'd0);
         tick();
      end
      op(0, 0, 0, 0, 0, 0);
      tick();
      check("rel_sel", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
      check("rel_stall", {29'd0, stall_f, stall_d, stall_em}, 32'd0);

      // ALU producer forwarding: next cycle -> 10, two cycles later -> 01, x0 -> 00.
      op(1, 0, 0, 5, 1, 0); tick();
      op(1, 5, 0, 0, 0, 0);
      check("alu_no_stall", 32'(stall_f), 32'd0);
      tick();
      check("fwd_a_mem", 32'(fwd_a_sel), 32'd2);
      op(1, 0, 0, 5, 1, 0); tick();
      op(0, 0, 0, 0, 0, 0); tick();
      op(1, 5, 0, 0, 0, 0); tick();
      check("fwd_a_wb", 32'(fwd_a_sel), 32'd1);
      op(1, 0, 0, 0, 1, 0); tick();
      op(1, 0, 0, 0, 0, 0); tick();
      check("fwd_a_x0", 32'(fwd_a_sel), 32'd0);

      // Load-use: one stall cycle, then forwarded from WB.
      op(1, 0, 0, 7, 1, 1); tick();
      op(1, 0, 7, 9, 1, 0);
      check("lu_stall", {27'd0, stall_f, stall_d, stall_em, flush_d, flush_e}, 32'b11001);
      tick();
      check("lu_cnt1", 32'(load_use_cnt), 32'd1);
      op(1, 0, 7, 9, 1, 0);
      check("lu_one_cycle", 32'(stall_f), 32'd0);
      tick();
      check("lu_fwd_b", 32'(fwd_b_sel), 32'd1);

      // Redirect outranks load-use.
      op(1, 0, 0, 3, 1, 1); tick();
      drive(1, 1, 3, 0, 0, 0, 0, 1, 0);
      check("redir_vs_lu", {27'd0, stall_f, stall_d, stall_em, flush_d, flush_e}, 32'b00011);
      tick();
      check("redir_cnt", 32'(load_use_cnt), 32'd1);

      // mem_busy freezes a pending redirect and the selects.
      op(1, 0, 0, 4, 1, 0); tick();
      op(1, 4, 0, 0, 0, 0); tick();
      check("busy_pre_sel", 32'(fwd_a_sel), 32'd2);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 4, 0, 0, 0, 0, 1, 1);
         check("busy_ctl", {27'd0, stall_f, stall_d, stall_em, flush_d, flush_e}, 32'b11100);
         tick();
         check("busy_sel_hold", 32'(fwd_a_sel), 32'd2);
      end
      drive(1, 1, 4, 0, 0, 0, 0, 1, 0);
      check("busy_release_flush", {30'd0, flush_d, flush_e}, 32'b11);
      tick();
      check("busy_release_sel", 32'(fwd_a_sel), 32'd0);

      // Counter saturation.
      for (int i = 0; i < CNT_MAX + 6; i++) begin
         op(1, 0, 0, 1, 1, 1); tick();
         op(1, 1, 0, 0, 0, 0); tick();
      end
      check("cnt_sat", 32'(load_use_cnt), 32'(CNT_MAX));

      // Randomized traffic with occasional mid-run resets.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 6) == 0), ($urandom_range(0, 4) == 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
